mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, counter width; PSC_W, default 4, prescaler width.
REQ-002 clk_i  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 clr_i  input  1  synchronous clear of counter and prescaler.
REQ-005 en_i  input  1  count enable; gates the prescaler.
REQ-006 we_i  input  1  synchronous load of dat_i.
REQ-007 dat_i  input  WIDTH  load value; any value is accepted, including values above max_i.
REQ-008 up_i  input  1  direction: 1 counts up, 0 counts down.
REQ-009 mode_i  input  1  terminal behaviour: 0 wraps, 1 saturates.
REQ-010 max_i  input  WIDTH  terminal value; the count range is 0..max_i.
REQ-011 psc_i  input  PSC_W  prescale divisor minus one; 0 means a step on every enabled cycle.
REQ-012 dat_o  output  WIDTH  current count, taken directly from a register.
REQ-013 tc_o  output  1  terminal-count pulse, registered.

Function
REQ-014 Priority SHALL be rst_i > clr_i > we_i > step; the highest active condition alone takes effect in a cycle.
REQ-015 Prescaler counter psc_cnt: with en_i=1, it increments; on psc_cnt==psc_i it returns to 0 and raises an internal tick in the same cycle.
REQ-016 With en_i=0, psc_cnt SHALL hold and no tick occurs.
REQ-017 step = en_i & tick & ~clr_i & ~we_i; dat_o SHALL reflect a step on the next rising edge (1-cycle latency).
REQ-018 Up step, dat_o<max_i: dat_o+1.
REQ-019 Up step, dat_o==max_i: wrap mode -> 0; saturate mode -> hold max_i.
REQ-020 Up step, dat_o>max_i: wrap mode -> 0; saturate mode -> max_i.
REQ-021 Down step, 0<dat_o<=max_i: dat_o-1.
REQ-022 Down step, dat_o==0: wrap mode -> max_i; saturate mode -> hold 0.
REQ-023 Down step, dat_o>max_i: max_i in both modes.
REQ-024 tc_o SHALL be 1 for exactly the cycle after a step taken at a terminal value (up: dat_o>=max_i; down: dat_o==0), and 0 otherwise, including in saturate mode while held.
REQ-025 clr_i: dat_o<=0, psc_cnt<=0, tc_o<=0.
REQ-026 we_i: dat_o<=dat_i, psc_cnt<=0, tc_o<=0.
REQ-027 max_i==0: wrap mode holds dat_o at 0 and pulses tc_o on every step.
REQ-028 Changes to psc_i, max_i, up_i or mode_i SHALL take effect in the same cycle they are presented; no internal latching.
REQ-029 Increment and decrement arithmetic SHALL be modulo 2^WIDTH with no carry output.

Reset
REQ-030 rst_i=1 at a rising edge: dat_o=0, tc_o=0, psc_cnt=0, regardless of all other inputs, including mid-prescale.
REQ-031 Outputs SHALL be defined (0) from the first clock edge with rst_i asserted; no asynchronous path exists.

Structure
REQ-032 A shared package SHALL hold MODE_WRAP=1'b0, MODE_SAT=1'b1, DIR_DOWN=1'b0, DIR_UP=1'b1.
REQ-033 Next-count arithmetic SHALL instantiate the team's full_adder sub-module: b_i=0 with cy_i=1 for increment; b_i=all-ones with cy_i=0 for decrement.
REQ-034 Registers SHALL be dat_o, psc_cnt and tc_o only; all other logic is combinational.

Verification
REQ-035 WIDTH=8, max_i=5, up, wrap, psc_i=0, en_i=1 for 8 cycles from reset -> dat_o 1,2,3,4,5,0,1,2; tc_o high only the cycle dat_o becomes 0.
REQ-036 psc_i=2, up, max_i=255, en_i=1 for 9 cycles -> dat_o increments on cycles 3,6,9; drop en_i for 2 cycles mid-period -> step is delayed by 2 cycles.
REQ-037 Down, saturate, we_i loads 2 -> dat_o 1,0,0,0; tc_o pulses on each step taken at 0 -> 0 never wraps to max_i.
REQ-038 Load dat_i=200 with max_i=10: up/wrap step -> 0 with tc_o=1; reload 200, down step -> 10; reload 200, up/saturate step -> 10.
REQ-039 clr_i, we_i and rst_i asserted together mid-prescale -> dat_o=0, tc_o=0 next cycle; repeat with we_i=1, dat_i=7 alone -> dat_o=7 and the prescaler restarts its full period.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared encodings for the modulo counter: terminal-mode and direction values.
package mod_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : mod_counter_pkg

// File: rtl/full_adder.sv
// Team full adder: WIDTH-bit sum of two operands plus a carry-in.
// The sum is modulo 2^WIDTH and no carry-out is produced.
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cy_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i + WIDTH'(cy_i);

endmodule : full_adder

// File: rtl/mod_counter.sv
// Prescaled up/down counter over the range 0..max_i with wrap or saturate
// terminal behaviour, synchronous load/clear and a registered terminal pulse.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             up_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic [PSC_W-1:0] psc_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             tc_q,  tc_d;

  logic             tick;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] addend;
  logic             carry_in;
  logic [WIDTH-1:0] cnt_adj;

  // The prescaler fires when its count matches the live divisor; psc_i is
  // compared directly so a new divisor applies in the cycle it appears.
  assign tick = en_i && (psc_q == psc_i);
  assign step = tick && !clr_i && !we_i;

  // One adder serves both directions: +0+1 for up, +all-ones+0 for down.
  assign addend   = (up_i == DIR_UP) ? '0 : '1;
  assign carry_in = (up_i == DIR_UP);

  full_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i   (cnt_q),
    .b_i   (addend),
    .cy_i  (carry_in),
    .sum_o (cnt_adj)
  );

  // A step is terminal at or above max going up, and only at zero going down;
  // a down step from above max just re-enters the range without a pulse.
  assign at_term = (up_i == DIR_UP) ? (cnt_q >= max_i) : (cnt_q == '0);

  // Next-state selection for count, prescaler and terminal pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    cnt_d = cnt_q;
    psc_d = psc_q;
    tc_d  = 1'b0;

    if (clr_i) begin
      cnt_d = '0;
      psc_d = '0;
    end else if (we_i) begin
      cnt_d = dat_i;
      psc_d = '0;
    end else begin
      if (en_i) begin
        psc_d = tick ? '0 : psc_q + PSC_W'(1);
      end

      if (step) begin
        tc_d = at_term;
        if (up_i == DIR_UP) begin
          if (cnt_q < max_i) begin
            cnt_d = cnt_adj;
          end else begin
            cnt_d = (mode_i == MODE_SAT) ? max_i : '0;
          end
        end else begin
          if (cnt_q > max_i) begin
            cnt_d = max_i;
          end else if (cnt_q == '0) begin
            cnt_d = (mode_i == MODE_SAT) ? '0 : max_i;
          end else begin
            cnt_d = cnt_adj;
          end
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (rst_i) begin
      cnt_q <= '0;
      psc_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      psc_q <= psc_d;
      tc_q  <= tc_d;
    end
  end

  assign dat_o = cnt_q;
  assign tc_o  = tc_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_mod_counter;
  import mod_counter_pkg::*;

  localparam int WIDTH = 8;
  localparam int PSC_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             en  = 1'b0;
  logic             we  = 1'b0;
  logic [WIDTH-1:0] dat_in = '0;
  logic             up   = DIR_UP;
  logic             mode = MODE_WRAP;
  logic [WIDTH-1:0] max_in = '0;
  logic [PSC_W-1:0] psc_in = '0;
  logic [WIDTH-1:0] dat_out;
  logic             tc_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH (WIDTH),
    .PSC_W (PSC_W)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (clr),
    .en_i   (en),
    .we_i   (we),
    .dat_i  (dat_in),
    .up_i   (up),
    .mode_i (mode),
    .max_i  (max_in),
    .psc_i  (psc_in),
    .dat_o  (dat_out),
    .tc_o   (tc_out)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int cnt;
    int psc;
    int tc;
  } model_t;

  model_t m = '{cnt: 0, psc: 0, tc: 0};
  bit     m_valid = 1'b0;

  function automatic model_t next_model(model_t s);
    model_t n;
    int     mx;
    bit     fire;
    n    = s;
    mx   = int'(max_in);
    fire = 1'b0;
    if (rst || clr) begin
      n = '{cnt: 0, psc: 0, tc: 0};
    end else if (we) begin
      n = '{cnt: int'(dat_in), psc: 0, tc: 0};
    end else begin
      n.tc = 0;
      if (en) begin
        if (s.psc == int'(psc_in)) begin
          fire  = 1'b1;
          n.psc = 0;
        end else begin
          n.psc = (s.psc + 1) % (1 << PSC_W);
        end
      end
      if (fire) begin
        if (up == DIR_UP) begin
          if (s.cnt < mx) n.cnt = s.cnt + 1;
          else begin
            n.tc  = 1;
            n.cnt = (mode == MODE_SAT) ? mx : 0;
          end
        end else begin
          if (s.cnt > mx) n.cnt = mx;
          else if (s.cnt == 0) begin
            n.tc  = 1;
            n.cnt = (mode == MODE_SAT) ? 0 : mx;
          end else n.cnt = s.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m       <= next_model(m);
    m_valid <= m_valid | rst;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_dat", int'(dat_out), m.cnt);
      check("cmp_tc", int'(tc_out), m.tc);
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic expect_state(input string name, input int d, input int t);
    check({name, "_dat"}, int'(dat_out), d);
    check({name, "_tc"}, int'(tc_out), t);
    check({name, "_model"}, m.cnt * 2 + m.tc, d * 2 + t);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clr = 1'b0; we = 1'b0; en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
  endtask

  int exp35[8] = '{1, 2, 3, 4, 5, 0, 1, 2};

  initial begin
    // Reset state
    tick_clk();
    expect_state("reset", 0, 0);
    idle_inputs();

    // Up/wrap with max 5, step every cycle
    max_in = 8'd5; up = DIR_UP; mode = MODE_WRAP; psc_in = '0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick_clk();
      expect_state($sformatf("wrap5_%0d", i), exp35[i], (exp35[i] == 0) ? 1 : 0);
    end

    // Prescaler divide-by-3 and enable gating
    do_reset();
    psc_in = 4'd2; max_in = 8'd255; en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick_clk();
      expect_state($sformatf("psc3_%0d", k), k / 3, 0);
    end
    tick_clk();                 // psc_cnt -> 1
    en = 1'b0;
    tick_clk(); tick_clk();     // held
    en = 1'b1;
    tick_clk();                 // psc_cnt -> 2
    expect_state("gate_hold", 3, 0);
    tick_clk();                 // tick, step
    expect_state("gate_step", 4, 0);

    // Down/saturate from a load of 2
    up = DIR_DOWN; mode = MODE_SAT; psc_in = '0; max_in = 8'd9;
    we = 1'b1; dat_in = 8'd2;
    tick_clk();
    expect_state("sat_load", 2, 0);
    we = 1'b0;
    tick_clk(); expect_state("sat_d1", 1, 0);
    tick_clk(); expect_state("sat_d0", 0, 0);
    tick_clk(); expect_state("sat_hold0", 0, 1);
    tick_clk(); expect_state("sat_hold1", 0, 1);

    // Loaded value above max
    max_in = 8'd10; dat_in = 8'd200;
    we = 1'b1; tick_clk(); we = 1'b0;
    up = DIR_UP; mode = MODE_WRAP;
    tick_clk(); expect_state("above_up_wrap", 0, 1);
    we = 1'b1; tick_clk(); we = 1'b0;
    up = DIR_DOWN;
    tick_clk(); expect_state("above_down", 10, 0);
    we = 1'b1; tick_clk(); we = 1'b0;
    up = DIR_UP; mode = MODE_SAT;
    tick_clk(); expect_state("above_up_sat", 10, 1);

    // max 0 in wrap mode pulses on every step
    do_reset();
    max_in = '0; up = DIR_UP; mode = MODE_WRAP; en = 1'b1;
    tick_clk(); expect_state("max0_a", 0, 1);
    tick_clk(); expect_state("max0_b", 0, 1);

    // Priority mid-prescale: rst, clr and we together
    do_reset();
    psc_in = 4'd3; max_in = 8'd255; en = 1'b1;
    tick_clk(); tick_clk();
    rst = 1'b1; clr = 1'b1; we = 1'b1; dat_in = 8'd7;
    tick_clk();
    expect_state("prio_all", 0, 0);
    rst = 1'b0; clr = 1'b0; we = 1'b0;
    tick_clk(); tick_clk();
    we = 1'b1;
    tick_clk();
    expect_state("prio_we", 7, 0);
    we = 1'b0;
    tick_clk(); tick_clk(); tick_clk();
    expect_state("restart_hold", 7, 0);
    tick_clk();
    expect_state("restart_step", 8, 0);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(63) == 0);
      clr    = ($urandom_range(31) == 0);
      we     = ($urandom_range(15) == 0);
      en     = ($urandom_range(3) != 0);
      up     = 1'($urandom_range(1));
      mode   = 1'($urandom_range(1));
      dat_in = 8'($urandom_range(255));
      if ($urandom_range(31) == 0) begin
        case ($urandom_range(3))
          0:       max_in = '0;
          1:       max_in = 8'd255;
          default: max_in = 8'($urandom_range(12));
        endcase
      end
      if ($urandom_range(15) == 0) begin
        psc_in = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
      end
      tick_clk();
    end

    idle_inputs();
    tick_clk();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mod_counter
